// File: rtl/ps2_c64_keymatrix_pkg.sv
// Shared definitions for the PS/2 set-2 to C64 keyboard matrix bridge:
// decoder states, prefix bytes, key positions and the lookup result type.
package ps2_c64_keymatrix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Bytes following E1 in the Pause sequence
   localparam logic [2:0] SKIP_BYTES = 3'd7;

   // Key positions written in octal as {col,row}
   localparam logic [5:0] KEY_RETURN   = 6'o01;
   localparam logic [5:0] KEY_CRSR_LR  = 6'o02;
   localparam logic [5:0] KEY_CRSR_UD  = 6'o07;
   localparam logic [5:0] KEY_A        = 6'o12;
   localparam logic [5:0] KEY_LSHIFT   = 6'o17;
   localparam logic [5:0] KEY_RSHIFT   = 6'o64;
   localparam logic [5:0] KEY_CTRL     = 6'o72;
   localparam logic [5:0] KEY_SPACE    = 6'o74;
   localparam logic [5:0] KEY_RUN_STOP = 6'o77;

   typedef struct packed {
      logic       valid;
      logic [2:0] col;
      logic [2:0] row;
      logic       restore;
   } keymap_t;

   function automatic keymap_t map_key(input logic [5:0] pos);
      keymap_t m;
      m.valid   = 1'b1;
      m.col     = pos[5:3];
      m.row     = pos[2:0];
      m.restore = 1'b0;
      return m;
   endfunction

   function automatic keymap_t map_restore();
      keymap_t m;
      m         = '0;
      m.valid   = 1'b1;
      m.restore = 1'b1;
      return m;
   endfunction

   // Keyboard self-test / ack / resend / error bytes carry no key information
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_c64_keymatrix_if.sv
// Byte stream in, CIA1 column drive in, row sense / RESTORE / event out.
interface ps2_c64_keymatrix_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic [7:0] col_sel;
   logic [7:0] row_out;
   logic       restore_n;
   logic       key_event;

   modport master (
      output rx_done_tick, rx_data, col_sel,
      input  row_out, restore_n, key_event
   );

   modport slave (
      input  rx_done_tick, rx_data, col_sel,
      output row_out, restore_n, key_event
   );
endinterface

// File: rtl/ps2_c64_keymatrix_keymap.sv
// Combinational PS/2 set-2 scancode to C64 matrix position lookup.
module ps2_c64_keymap
   import ps2_c64_keymatrix_pkg::*;
(
   input  logic       i_ext,
   input  logic [7:0] i_code,
   output keymap_t    o_map
);

   always_comb begin
      o_map = '0;
      case ({i_ext, i_code})
         9'h01C: o_map = map_key(KEY_A);
         9'h032: o_map = map_key(6'o34);
         9'h021: o_map = map_key(6'o24);
         9'h023: o_map = map_key(6'o22);
         9'h024: o_map = map_key(6'o16);
         9'h02B: o_map = map_key(6'o25);
         9'h034: o_map = map_key(6'o32);
         9'h033: o_map = map_key(6'o35);
         9'h043: o_map = map_key(6'o41);
         9'h03B: o_map = map_key(6'o42);
         9'h042: o_map = map_key(6'o45);
         9'h04B: o_map = map_key(6'o52);
         9'h03A: o_map = map_key(6'o44);
         9'h031: o_map = map_key(6'o47);
         9'h044: o_map = map_key(6'o46);
         9'h04D: o_map = map_key(6'o51);
         9'h015: o_map = map_key(6'o76);
         9'h02D: o_map = map_key(6'o21);
         9'h01B: o_map = map_key(6'o15);
         9'h02C: o_map = map_key(6'o26);
         9'h03C: o_map = map_key(6'o36);
         9'h02A: o_map = map_key(6'o37);
         9'h01D: o_map = map_key(6'o11);
         9'h022: o_map = map_key(6'o27);
         9'h035: o_map = map_key(6'o31);
         9'h01A: o_map = map_key(6'o14);
         9'h016: o_map = map_key(6'o70);
         9'h01E: o_map = map_key(6'o73);
         9'h026: o_map = map_key(6'o10);
         9'h025: o_map = map_key(6'o13);
         9'h02E: o_map = map_key(6'o20);
         9'h036: o_map = map_key(6'o23);
         9'h03D: o_map = map_key(6'o30);
         9'h03E: o_map = map_key(6'o33);
         9'h046: o_map = map_key(6'o40);
         9'h045: o_map = map_key(6'o43);
         9'h041: o_map = map_key(6'o57);
         9'h049: o_map = map_key(6'o54);
         9'h04A: o_map = map_key(6'o67);
         9'h04C: o_map = map_key(6'o62);
         9'h04E: o_map = map_key(6'o53);
         9'h055: o_map = map_key(6'o65);
         9'h066: o_map = map_key(6'o00);
         9'h005: o_map = map_key(6'o04);
         9'h004: o_map = map_key(6'o05);
         9'h003: o_map = map_key(6'o06);
         9'h083: o_map = map_key(6'o03);
         9'h012: o_map = map_key(KEY_LSHIFT);
         9'h059: o_map = map_key(KEY_RSHIFT);
         9'h029: o_map = map_key(KEY_SPACE);
         9'h05A: o_map = map_key(KEY_RETURN);
         9'h076: o_map = map_key(KEY_RUN_STOP);
         9'h014: o_map = map_key(KEY_CTRL);
         9'h174: o_map = map_key(KEY_CRSR_LR);
         9'h172: o_map = map_key(KEY_CRSR_UD);
         9'h16C: o_map = map_key(6'o63);
         9'h17D: o_map = map_restore();
         default: o_map = '0;
      endcase
   end

endmodule

// File: rtl/ps2_c64_keymatrix.sv
// PS/2 scancode decoder driving an emulated C64 keyboard matrix scanned by CIA1.
module ps2_c64_keymatrix
   import ps2_c64_keymatrix_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                 clk,
   input  logic                 reset,
   ps2_c64_keymatrix_if.slave   bus
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_skip_cnt;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic [7:0][7:0]   r_pressed;
   logic              r_restore;
   logic              r_key_event;
   logic [7:0]        r_row_out;

   logic              w_apply;
   logic              w_ext;
   logic              w_brk;
   logic              w_timeout;
   logic              w_key_hit;
   keymap_t           w_map;
   logic [7:0]        w_row_hit;

   ps2_c64_keymap u_keymap (
      .i_ext  (w_ext),
      .i_code (bus.rx_data),
      .o_map  (w_map)
   );

   always_comb begin
      w_state_next = r_state;
      w_apply      = 1'b0;
      w_ext        = 1'b0;
      w_brk        = 1'b0;
      w_timeout    = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_LAST);
      if (bus.rx_done_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.rx_data == PS2_EXT)        w_state_next = ST_EXT;
               else if (bus.rx_data == PS2_BRK)   w_state_next = ST_BRK;
               else if (bus.rx_data == PS2_PAUSE) w_state_next = ST_SKIP;
               else if (!is_status_byte(bus.rx_data)) w_apply = 1'b1;
            end
            ST_EXT: begin
               if (bus.rx_data == PS2_BRK) begin
                  w_state_next = ST_EXT_BRK;
               end else begin
                  w_apply      = 1'b1;
                  w_ext        = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_apply      = 1'b1;
               w_brk        = 1'b1;
               w_state_next = ST_IDLE;
            end
            ST_EXT_BRK: begin
               w_apply      = 1'b1;
               w_ext        = 1'b1;
               w_brk        = 1'b1;
               w_state_next = ST_IDLE;
            end
            ST_SKIP: begin
               if (r_skip_cnt == 3'd1) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_next = ST_IDLE;
      end
   end

   assign w_key_hit = w_apply & w_map.valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_skip_cnt  <= '0;
         r_tmo_cnt   <= '0;
         r_pressed   <= '0;
         r_restore   <= 1'b0;
         r_key_event <= 1'b0;
         r_row_out   <= 8'hFF;
      end else begin
         r_key_event <= w_key_hit;
         r_row_out   <= ~w_row_hit;

         if (bus.rx_done_tick || r_state == ST_IDLE) begin
            r_tmo_cnt <= '0;
         end else if (r_tmo_cnt != TMO_LAST) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end

         if (bus.rx_done_tick && r_state == ST_IDLE && bus.rx_data == PS2_PAUSE) begin
            r_skip_cnt <= SKIP_BYTES;
         end else if (bus.rx_done_tick && r_state == ST_SKIP) begin
            r_skip_cnt <= r_skip_cnt - 1'b1;
         end

         // RESTORE sits outside the matrix on the real machine (NMI line)
         if (w_key_hit) begin
            if (w_map.restore) r_restore <= ~w_brk;
            else               r_pressed[w_map.col][w_map.row] <= ~w_brk;
         end
      end
   end

   // Any selected column with a pressed key pulls its row low
   for (genvar gi = 0; gi < 8; gi++) begin : g_row
      logic [7:0] w_hits;
      for (genvar gc = 0; gc < 8; gc++) begin : g_col
         assign w_hits[gc] = r_pressed[gc][gi] & ~bus.col_sel[gc];
      end
      assign w_row_hit[gi] = |w_hits;
   end

   assign bus.row_out   = r_row_out;
   assign bus.restore_n = ~r_restore;
   assign bus.key_event = r_key_event;

endmodule

// File: tb/tb_ps2_c64_keymatrix.sv
// Scoreboarded bench: each expected key_event is queued with its row/RESTORE result.
module tb_ps2_c64_keymatrix;

   localparam int TMO = 40;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ps2_c64_keymatrix_if bus();

   ps2_c64_keymatrix #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] row;
      logic       restore_n;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec     = 0;
   int   n_err     = 0;
   int   n_ev_seen = 0;
   int   n_ev_exp  = 0;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Result of an event is checked one cycle after the pulse (row_out latency)
   always @(negedge clk) begin
      if (bus.key_event === 1'b1) begin
         n_ev_seen++;
         check_val("ev_expected", 8'(sb_q.size() != 0), 8'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            @(negedge clk);
            $display("event %0d: row_out=%h restore_n=%b", n_ev_seen, bus.row_out, bus.restore_n);
            check_val("ev_row_out", bus.row_out, mon_e.row);
            check_val("ev_restore_n", 8'(bus.restore_n), 8'(mon_e.restore_n));
         end
      end
   end

   task automatic tick_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data      = b;
      bus.rx_done_tick = 1'b1;
      @(posedge clk); #1;
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic send_ev(input logic [7:0] b, input logic [7:0] row, input logic rn);
      exp_t e;
      e.row       = row;
      e.restore_n = rn;
      sb_q.push_back(e);
      n_ev_exp++;
      tick_byte(b);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic set_cols(input logic [7:0] v);
      @(posedge clk); #1;
      bus.col_sel = v;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.col_sel      = 8'h00;
      reset            = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_row_out", bus.row_out, 8'hFF);
      check_val("rst_restore_n", 8'(bus.restore_n), 8'd1);
      check_val("rst_key_event", 8'(bus.key_event), 8'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("post_rst_row_out", bus.row_out, 8'hFF);

      // A make then break
      set_cols(8'hFD);
      send_ev(8'h1C, 8'hFB, 1'b1);
      tick_byte(8'hF0);
      send_ev(8'h1C, 8'hFF, 1'b1);
      settle();
      check_val("two_events", 8'(n_ev_seen), 8'd2);

      // Typematic repeat and break of an unpressed key
      send_ev(8'h1C, 8'hFB, 1'b1);
      send_ev(8'h1C, 8'hFB, 1'b1);
      tick_byte(8'hF0);
      send_ev(8'h1C, 8'hFF, 1'b1);
      tick_byte(8'hF0);
      send_ev(8'h1C, 8'hFF, 1'b1);
      settle();

      // LSHIFT + A in the same column
      send_ev(8'h12, 8'h7F, 1'b1);
      send_ev(8'h1C, 8'h7B, 1'b1);
      settle();
      set_cols(8'hFF);
      check_val("no_col_rows", bus.row_out, 8'hFF);
      set_cols(8'hFD);
      check_val("col1_rows", bus.row_out, 8'h7B);
      tick_byte(8'hF0);
      send_ev(8'h12, 8'hFB, 1'b1);
      tick_byte(8'hF0);
      send_ev(8'h1C, 8'hFF, 1'b1);
      settle();

      // Two columns selected: rows combine
      set_cols(8'h7D);
      send_ev(8'h1C, 8'hFB, 1'b1);
      send_ev(8'h29, 8'hEB, 1'b1);
      settle();
      check_val("two_col_rows", bus.row_out, 8'hEB);
      set_cols(8'h7F);
      check_val("col7_rows", bus.row_out, 8'hEF);
      tick_byte(8'hF0);
      send_ev(8'h1C, 8'hEF, 1'b1);
      tick_byte(8'hF0);
      send_ev(8'h29, 8'hFF, 1'b1);
      settle();

      // RESTORE make/break leaves the matrix alone
      set_cols(8'h00);
      tick_byte(8'hE0);
      send_ev(8'h7D, 8'hFF, 1'b0);
      settle();
      check_val("restore_held", 8'(bus.restore_n), 8'd0);
      check_val("restore_rows", bus.row_out, 8'hFF);
      tick_byte(8'hE0);
      tick_byte(8'hF0);
      send_ev(8'h7D, 8'hFF, 1'b1);
      settle();

      // Pause sequence is swallowed
      tick_byte(8'hE1);
      tick_byte(8'h14);
      tick_byte(8'h77);
      tick_byte(8'hE1);
      tick_byte(8'hF0);
      tick_byte(8'h14);
      tick_byte(8'hF0);
      tick_byte(8'h77);
      set_cols(8'h7F);
      send_ev(8'h29, 8'hEF, 1'b1);
      settle();
      set_cols(8'h00);
      check_val("only_space", bus.row_out, 8'hEF);
      tick_byte(8'hF0);
      send_ev(8'h29, 8'hFF, 1'b1);
      settle();

      // Stale E0 prefix expires
      set_cols(8'hFE);
      tick_byte(8'hE0);
      repeat (TMO + 10) @(posedge clk);
      tick_byte(8'h74);
      settle();
      check_val("tmo_rows", bus.row_out, 8'hFF);
      check_val("tmo_no_event", 8'(n_ev_seen), 8'(n_ev_exp));
      tick_byte(8'hE0);
      send_ev(8'h74, 8'hFB, 1'b1);
      settle();
      tick_byte(8'hE0);
      tick_byte(8'hF0);
      send_ev(8'h74, 8'hFF, 1'b1);
      settle();

      // Reset mid-prefix clears matrix and prefix
      set_cols(8'h7F);
      send_ev(8'h29, 8'hEF, 1'b1);
      send_ev(8'h29, 8'hEF, 1'b1);
      send_ev(8'h29, 8'hEF, 1'b1);
      settle();
      tick_byte(8'hE0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_val("mid_rst_row_out", bus.row_out, 8'hFF);
      check_val("mid_rst_key_event", 8'(bus.key_event), 8'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      set_cols(8'h00);
      check_val("after_rst_rows", bus.row_out, 8'hFF);
      set_cols(8'hFE);
      send_ev(8'h5A, 8'hFD, 1'b1);
      settle();

      repeat (4) @(negedge clk);
      check_val("sb_drained", 8'(sb_q.size()), 8'd0);
      check_val("event_total", 8'(n_ev_seen), 8'(n_ev_exp));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_c64_keymatrix.md
PS2_C64_KEYMATRIX -- requirements
Module: ps2_c64_keymatrix

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000; idle cycles after which a pending prefix (E0/F0/E1) is discarded.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver; rx_data valid this cycle.
REQ-005 rx_data  input  8  received PS/2 set-2 scancode byte.
REQ-006 col_sel  input  8  CIA1 port A column drive, active-low, bit c selects column c.
REQ-007 row_out  output  8  CIA1 port B row sense, active-low.
REQ-008 restore_n  output  1  RESTORE key, active-low, low while held.
REQ-009 key_event  output  1  one-cycle pulse on every applied make/break.

Function
REQ-010 Key state SHALL be a 64-bit pressed array indexed [col][row], where 1 means pressed.
REQ-011 The decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen) and SKIP (E1 sequence).
REQ-012 Transitions on rx_done_tick: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; IDLE+E1->SKIP with skip count 7; IDLE+AA/FA/EE/FE/00/FF->IDLE with no effect; any other byte->apply, then IDLE.
REQ-013 Apply SHALL look up {ext, code} in a combinational map giving {valid, col[2:0], row[2:0], is_restore}; an invalid entry is ignored with no key_event.
REQ-014 A valid apply SHALL set pressed[col][row] to 1 for a make and 0 for a break (BRK/EXT_BRK), and SHALL pulse key_event on the following cycle.
REQ-015 When is_restore is set, apply SHALL drive a restore flag instead of the matrix; restore_n = ~flag.
REQ-016 SKIP SHALL decrement the count on each byte and return to IDLE after the 7th byte; no matrix change occurs.
REQ-017 Timeout counter: cleared on every rx_done_tick; in any state other than IDLE it saturates at TIMEOUT_CYCLES-1 and then forces IDLE.
REQ-018 row_out[r] SHALL be registered as ~OR over c of (pressed[c][r] & ~col_sel[c]), giving 1-cycle latency from col_sel or from a matrix change.
REQ-019 A repeated make (typematic) SHALL be idempotent; a break for a key not pressed SHALL be a no-op.
REQ-020 Minimum map: 1C->A(1,2); 12 and 59->LSHIFT(1,7)/RSHIFT(6,4); 29->SPACE(7,4); 5A->RETURN(0,1); E0 74->CRSR_LR(0,2); E0 72->CRSR_UD(0,7); 76->RUN/STOP(7,7); 14->CTRL(7,2); E0 7D->RESTORE. Remaining alphanumerics follow the standard C64 matrix.
REQ-021 When two columns are selected at once, their rows SHALL be wire-ANDed per REQ-018; no ghost-key suppression is applied.

Reset
REQ-022 Reset SHALL clear the pressed array and restore flag, set the FSM to IDLE, and clear the skip and timeout counters.
REQ-023 During and after reset: row_out=8'hFF, restore_n=1, key_event=0.
REQ-024 Reset asserted mid-sequence (e.g. after E0) SHALL discard the prefix; the next byte is decoded from IDLE.

Structure
REQ-025 Shared package: FSM state encoding, the prefix constants E0/F0/E1, and the {col,row} indices of the named C64 keys.
REQ-026 A single sub-module, ps2_c64_keymap, SHALL hold the purely combinational scancode-to-matrix lookup; the FSM, matrix, timeout and row scan stay in the top level.

Verification
REQ-027 Bytes 1C, col_sel=8'hFD -> row_out=8'hFB one cycle after the apply; then F0 1C -> row_out=8'hFF and two key_event pulses in total.
REQ-028 Bytes 12, 1C with col_sel=8'hFD -> row_out=8'h7B; with col_sel=8'hFF -> row_out=8'hFF.
REQ-029 Bytes E0 7D -> restore_n=0 with the matrix unchanged; E0 F0 7D -> restore_n=1.
REQ-030 E1 followed by 7 bytes (14 77 E1 F0 14 F0 77), then 29, col_sel=8'h7F -> only SPACE pressed, row_out=8'hEF.
REQ-031 E0, then TIMEOUT_CYCLES idle cycles, then 74 -> no change (74 is unmapped unextended); a repeat with E0 74 inside the timeout -> CRSR_LR pressed.
REQ-032 Bytes 29 29 29, reset pulse, then col_sel=8'h00 -> row_out=8'hFF; next byte 5A -> RETURN pressed, row_out=8'hFD with col_sel=8'hFE.
